ss_stream_fifo: RTL

SS_STREAM_FIFO -- requirements
Module: ss_stream_fifo

---
 rtl/user_stream_pkg.sv | 13 +
 rtl/ss_stream_fifo_if.sv | 26 ++
 rtl/ss_fifo_mem.sv | 22 ++
 rtl/ss_stream_fifo.sv | 90 +++++++++
 4 files changed

// File: rtl/user_stream_pkg.sv
// Shared defaults and sizing helpers for the stream FIFO slice.
package user_stream_pkg;

  localparam int USP_DATA_W = 32;
  localparam int USP_DEPTH  = 8;
  localparam int USP_LEN_W  = 10;

  // Occupancy needs one bit more than the pointer to represent a full FIFO.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ss_stream_fifo_if.sv
// Upstream/downstream valid-ready stream pair carried by the FIFO.
interface ss_stream_fifo_if #(
  parameter int DATA_W = user_stream_pkg::USP_DATA_W
);

  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] s_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;

  // FIFO side
  modport slave (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );

  // Environment side: drives the upstream beats and the downstream ready
  modport master (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );

endinterface

// File: rtl/ss_fifo_mem.sv
// FIFO storage: register array, one synchronous write port, one async read port.
module ss_fifo_mem #(
  parameter int DATA_W = user_stream_pkg::USP_DATA_W,
  parameter int DEPTH  = user_stream_pkg::USP_DEPTH
) (
  input  logic                     wb_clk_i,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge wb_clk_i) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ss_stream_fifo.sv
// First-word-fall-through stream FIFO with frame-length based tlast and frame-done pulse.
module ss_stream_fifo
  import user_stream_pkg::*;
#(
  parameter int DATA_W = USP_DATA_W,
  parameter int DEPTH  = USP_DEPTH,
  parameter int LEN_W  = USP_LEN_W
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        clr_i,
  input  logic [LEN_W-1:0]            frame_len_i,
  ss_stream_fifo_if.slave             bus,
  output logic [level_w(DEPTH)-1:0]   level_o,
  output logic                        frame_done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);
  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [LEN_W-1:0]  beat_q;
  logic              frame_done_q;
  logic [LEN_W-1:0]  last_beat;
  logic              wr_en;
  logic              rd_en;
  logic              tlast;
  logic [DATA_W-1:0] rd_data;

  // Handshake flags derive only from registered occupancy, so m_tready never reaches s_tready.
  always_comb begin
    last_beat = frame_len_i - LEN_ONE;
    wr_en     = bus.s_tvalid && (level_q != LVL_FULL);
    rd_en     = (level_q != '0) && bus.m_tready;
    tlast     = (level_q != '0) && (beat_q == last_beat);
  end

  assign bus.s_tready = (level_q != LVL_FULL);
  assign bus.m_tvalid = (level_q != '0);
  assign bus.m_tdata  = rd_data;
  assign bus.m_tlast  = tlast;
  assign level_o      = level_q;
  assign frame_done_o = frame_done_q;

  // Pointer/occupancy/frame state; clr_i flushes and overrides any same-cycle transfer.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      beat_q       <= '0;
      frame_done_q <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      beat_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= rd_en && tlast;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        beat_q   <= tlast ? '0 : beat_q + LEN_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  ss_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .wb_clk_i (wb_clk_i),
    .we       (wr_en && !clr_i),
    .waddr    (wr_ptr_q),
    .wdata    (bus.s_tdata),
    .raddr    (rd_ptr_q),
    .rdata    (rd_data)
  );

endmodule
